bcd_conv_arbiter: RTL

//  Round-robin arbiter/sequencer sharing one binary-to-BCD converter core among
//  NUM_REQ requesters (e.g. display channels). Captures a requester's binary word,

---
 rtl/bcd_conv_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/bcd_conv_arbiter.sv
// Round-robin sequencer that shares one binary-to-BCD converter among
// NUM_REQ requesters. A granted requester's operand is launched into the
// converter, and the result (or a timeout error) is returned tagged with the
// requester index.
module bcd_conv_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int BIN_W   = 13,
    parameter int BCD_W   = 16,
    parameter int TIMEOUT = 31
) (
    input  logic                        i_clk_1mhz,
    input  logic                        i_reset,
    input  logic [NUM_REQ-1:0]          i_req,
    input  logic [NUM_REQ*BIN_W-1:0]    i_req_data,
    output logic [NUM_REQ-1:0]          o_grant,
    output logic                        o_rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]  o_rsp_id,
    output logic [BCD_W-1:0]            o_rsp_bcd,
    output logic                        o_rsp_err,
    output logic                        o_busy,
    output logic                        o_conv_start,
    output logic [BIN_W-1:0]            o_conv_data,
    input  logic                        i_conv_done,
    input  logic [BCD_W-1:0]            i_conv_bcd
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT);
    localparam logic [ID_W:0]    REQ_CNT  = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0]  LAST_IDX = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DELIVER = 2'd2
    } state_t;

    state_t              state, state_nx;
    logic [ID_W-1:0]     ptr, ptr_nx;
    logic [TMR_W-1:0]    timer, timer_nx;
    logic [NUM_REQ-1:0]  grant_nx;
    logic                start_nx;
    logic                rsp_valid_nx;
    logic [ID_W-1:0]     rsp_id_nx;
    logic [BCD_W-1:0]    rsp_bcd_nx;
    logic                rsp_err_nx;
    logic [BIN_W-1:0]    conv_data_nx;

    logic                pick_found;
    logic [ID_W-1:0]     pick_idx;
    logic [ID_W-1:0]     pick_next;
    logic [BIN_W-1:0]    pick_data;
    logic [ID_W:0]       cand_sum;
    logic [ID_W-1:0]     cand_idx;

    logic [BIN_W-1:0]    operand [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign operand[g] = i_req_data[g*BIN_W +: BIN_W];
    end

    assign o_busy = (state != S_IDLE);

    // Round-robin search: first requesting index at or above the pointer, wrapping
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_next  = '0;
        pick_data  = '0;
        cand_sum   = '0;
        cand_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_sum = {1'b0, ptr} + (ID_W + 1)'(i);
            if (cand_sum >= REQ_CNT) begin
                cand_sum = cand_sum - REQ_CNT;
            end
            cand_idx = cand_sum[ID_W-1:0];
            if (!pick_found && i_req[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
                pick_next  = (cand_idx == LAST_IDX) ? '0 : cand_idx + 1'b1;
                pick_data  = operand[cand_idx];
            end
        end
    end

    // Next-state and next-output decode for the IDLE -> WAIT -> DELIVER sequence
    always_comb begin
        state_nx     = state;
        ptr_nx       = ptr;
        timer_nx     = timer;
        grant_nx     = '0;
        start_nx     = 1'b0;
        rsp_valid_nx = 1'b0;
        rsp_id_nx    = o_rsp_id;
        rsp_bcd_nx   = o_rsp_bcd;
        rsp_err_nx   = o_rsp_err;
        conv_data_nx = o_conv_data;
        case (state)
            S_IDLE: begin
                if (pick_found) begin
                    grant_nx[pick_idx] = 1'b1;
                    conv_data_nx       = pick_data;
                    start_nx           = 1'b1;
                    rsp_id_nx          = pick_idx;
                    ptr_nx             = pick_next;
                    timer_nx           = '0;
                    state_nx           = S_WAIT;
                end
            end
            S_WAIT: begin
                // A done seen in the same cycle as our own launch pulse cannot
                // belong to this conversion, so it is ignored.
                if (i_conv_done && !o_conv_start) begin
                    rsp_bcd_nx   = i_conv_bcd;
                    rsp_err_nx   = 1'b0;
                    rsp_valid_nx = 1'b1;
                    state_nx     = S_DELIVER;
                end else if (timer == TMR_LAST) begin
                    rsp_bcd_nx   = '0;
                    rsp_err_nx   = 1'b1;
                    rsp_valid_nx = 1'b1;
                    state_nx     = S_DELIVER;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            S_DELIVER: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything and drops any in-flight conversion
    always_ff @(posedge i_clk_1mhz or posedge i_reset) begin
        if (i_reset) begin
            state        <= S_IDLE;
            ptr          <= '0;
            timer        <= '0;
            o_grant      <= '0;
            o_conv_start <= 1'b0;
            o_conv_data  <= '0;
            o_rsp_valid  <= 1'b0;
            o_rsp_id     <= '0;
            o_rsp_bcd    <= '0;
            o_rsp_err    <= 1'b0;
        end else begin
            state        <= state_nx;
            ptr          <= ptr_nx;
            timer        <= timer_nx;
            o_grant      <= grant_nx;
            o_conv_start <= start_nx;
            o_conv_data  <= conv_data_nx;
            o_rsp_valid  <= rsp_valid_nx;
            o_rsp_id     <= rsp_id_nx;
            o_rsp_bcd    <= rsp_bcd_nx;
            o_rsp_err    <= rsp_err_nx;
        end
    end

endmodule
